matrix_multiplication: RTL and testbench

4×4 matrix multiplier slave of the execution engine. The engine loads two 256-bit operand matrices over its module bus, then requests the product. The block computes C = A × B with 16-bit wrap-around arithmetic and returns C on a dedicated 256-bit result bus with a completion flag.

---
 rtl/matmul_pkg.sv | 15 +
 rtl/matrix_multiplication_if.sv | 15 +
 rtl/matmul_dot4.sv | 18 +
 rtl/matrix_multiplication.sv | 123 ++++++++++++
 tb/tb_matrix_multiplication.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and element-slice helper for the 4x4 matrix multiplier.
package matmul_pkg;

    localparam int DIM  = 4;
    localparam int EW   = 16;
    localparam int BUSW = 256;

    typedef enum logic [1:0] {IDLE, CALC, DONE, ACK} stateT;

    // Element [row][col] lives at bits [(4*row+col)*16 +: 16] of a packed matrix.
    function automatic logic [7:0] elemOffset(input logic [1:0] row, input logic [1:0] col);
        return {row, col, 4'b0000};
    endfunction

endpackage

// File: rtl/matrix_multiplication_if.sv
// Module bus between the execution engine (master) and the matrix multiplier (slave).
interface matrix_multiplication_if;
    import matmul_pkg::*;

    logic [BUSW-1:0] dataIn;
    logic            multRW;
    logic            multEN;
    logic            matDecide;
    logic [BUSW-1:0] dataOut;
    logic            multFleg;

    modport master (output dataIn, multRW, multEN, matDecide, input dataOut, multFleg);
    modport slave  (input dataIn, multRW, multEN, matDecide, output dataOut, multFleg);

endinterface

// File: rtl/matmul_dot4.sv
// Combinational 4-term dot product, each product and the sum kept modulo 2^16.
module matmul_dot4
    import matmul_pkg::*;
(
    input  logic [DIM-1:0][EW-1:0] rowVec,
    input  logic [DIM-1:0][EW-1:0] colVec,
    output logic [EW-1:0]          dot
);

    always_comb begin
        dot = '0;
        // NOTE: blocking assignments are correct here; the accumulation is combinational.
        for (int k = 0; k < DIM; k++) begin
            dot = dot + rowVec[k] * colVec[k];
        end
    end

endmodule

// File: rtl/matrix_multiplication.sv
// 4x4 16-bit wrap-around matrix multiplier slave (C = A x B).
// Build option MATMUL_FAST_EN: all 16 elements in one cycle instead of a 16-cycle MAC walk.
module matrix_multiplication
    import matmul_pkg::*;
(
    input  logic                    clk,
    input  logic                    RESET,
    matrix_multiplication_if.slave  bus
);

    stateT           state;
    stateT           stateNext;
    logic [BUSW-1:0] matA;
    logic [BUSW-1:0] matB;
    logic [BUSW-1:0] matC;
    logic [BUSW-1:0] matCNext;
    logic            loadAccept;
    logic            calcAccept;

    assign loadAccept = (state == IDLE) && bus.multEN && !bus.multRW;
    assign calcAccept = (state == IDLE) && bus.multEN &&  bus.multRW;

`ifdef MATMUL_FAST_EN
    logic [DIM*DIM-1:0][EW-1:0] fastDots;

    for (genvar r = 0; r < DIM; r++) begin : gRow
        for (genvar c = 0; c < DIM; c++) begin : gCol
            logic [DIM-1:0][EW-1:0] rowVec;
            logic [DIM-1:0][EW-1:0] colVec;

            always_comb begin
                for (int k = 0; k < DIM; k++) begin
                    rowVec[k] = matA[elemOffset(2'(r), 2'(k)) +: EW];
                    colVec[k] = matB[elemOffset(2'(k), 2'(c)) +: EW];
                end
            end

            matmul_dot4 uDot (.rowVec(rowVec), .colVec(colVec), .dot(fastDots[r*DIM+c]));
        end
    end

    always_comb begin
        matCNext = matC;
        if (calcAccept) matCNext = fastDots;
    end
`else
    logic [3:0]             index;
    logic [DIM-1:0][EW-1:0] selRow;
    logic [DIM-1:0][EW-1:0] selCol;
    logic [EW-1:0]          dotOut;

    // Index walks C in row-major order: row = index[3:2], col = index[1:0].
    always_comb begin
        for (int k = 0; k < DIM; k++) begin
            selRow[k] = matA[elemOffset(index[3:2], 2'(k)) +: EW];
            selCol[k] = matB[elemOffset(2'(k), index[1:0]) +: EW];
        end
    end

    matmul_dot4 uDot (.rowVec(selRow), .colVec(selCol), .dot(dotOut));

    always_comb begin
        matCNext = matC;
        if (state == CALC && bus.multEN) matCNext[elemOffset(index[3:2], index[1:0]) +: EW] = dotOut;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET)                index <= '0;
        else if (calcAccept)      index <= '0;
        else if (state == CALC)   index <= index + 4'd1;
    end
`endif

    always_comb begin
        // NOTE: default first on every path so the next-state logic never infers a latch.
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (loadAccept) stateNext = ACK;
`ifdef MATMUL_FAST_EN
                else if (calcAccept) stateNext = DONE;
`else
                else if (calcAccept) stateNext = CALC;
`endif
            end
`ifdef MATMUL_FAST_EN
            CALC: stateNext = IDLE;
`else
            CALC: begin
                if (!bus.multEN)        stateNext = IDLE;
                else if (index == 4'd15) stateNext = DONE;
            end
`endif
            DONE:    if (!bus.multEN) stateNext = IDLE;
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they change exactly with the state.
    always_ff @(posedge clk or posedge RESET) begin
        // NOTE: operand and result storage is reset as well, so a product right after reset is all zeros.
        if (RESET) begin
            state        <= IDLE;
            matA         <= '0;
            matB         <= '0;
            matC         <= '0;
            bus.dataOut  <= '0;
            bus.multFleg <= 1'b0;
        end else begin
            // NOTE: all sequential state updates use non-blocking assignments.
            state        <= stateNext;
            matC         <= matCNext;
            bus.dataOut  <= (stateNext == DONE) ? matCNext : '0;
            bus.multFleg <= (stateNext == DONE) || (stateNext == ACK);
            if (loadAccept) begin
                if (bus.matDecide) matB <= bus.dataIn;
                else               matA <= bus.dataIn;
            end
        end
    end

endmodule

// File: tb/tb_matrix_multiplication.sv
// Self-checking bench: transaction-level model of loads, products, aborts and resets.
module tb_matrix_multiplication;
    import matmul_pkg::*;

`ifdef MATMUL_FAST_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 16;
`endif

    typedef logic [EW-1:0] matT [DIM][DIM];

    logic clk   = 1'b0;
    logic RESET = 1'b1;

    matrix_multiplication_if bus ();
    matrix_multiplication dut (.clk(clk), .RESET(RESET), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Model state: operand matrices, pending product, and what the block is doing.
    matT             modA;
    matT             modB;
    logic [BUSW-1:0] expProd;
    int              busyLeft;
    bit              inAck;
    bit              inDone;

    task automatic check(input string name, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BUSW-1:0] packMat(input matT m);
        logic [BUSW-1:0] v;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                v[(i*DIM+j)*EW +: EW] = m[i][j];
        return v;
    endfunction

    function automatic logic [BUSW-1:0] matMul(input matT a, input matT b);
        logic [BUSW-1:0] v;
        logic [31:0]     s;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int k = 0; k < DIM; k++) s += 32'(a[i][k]) * 32'(b[k][j]);
                v[(i*DIM+j)*EW +: EW] = s[15:0];
            end
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                modA[i][j] = '0;
                modB[i][j] = '0;
            end
        expProd  = '0;
        busyLeft = 0;
        inAck    = 1'b0;
        inDone   = 1'b0;
    endtask

    // One rising edge as seen by the engine: what the block must do with these inputs.
    task automatic modelEdge(input bit en, input bit rw, input bit dec, input logic [BUSW-1:0] d);
        if (inAck) begin
            inAck = 1'b0;
        end else if (inDone) begin
            if (!en) inDone = 1'b0;
        end else if (busyLeft > 0) begin
            if (!en) busyLeft = 0;
            else begin
                busyLeft--;
                if (busyLeft == 0) inDone = 1'b1;
            end
        end else if (en && !rw) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    if (dec) modB[i][j] = d[(i*DIM+j)*EW +: EW];
                    else     modA[i][j] = d[(i*DIM+j)*EW +: EW];
                end
            inAck = 1'b1;
        end else if (en && rw) begin
            expProd  = matMul(modA, modB);
            busyLeft = LAT;
            if (busyLeft == 0) inDone = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("multFleg", {255'd0, bus.multFleg}, {255'd0, inAck || inDone});
            check("dataOut", bus.dataOut, inDone ? expProd : '0);
        end
    end

    task automatic step(input bit en, input bit rw, input bit dec, input logic [BUSW-1:0] d);
        bus.multEN    = en;
        bus.multRW    = rw;
        bus.matDecide = dec;
        bus.dataIn    = d;
        @(posedge clk);
        modelEdge(en, rw, dec, d);
        #1;
    endtask

    task automatic loadMat(input bit dec, input matT m);
        step(1'b1, 1'b0, dec, packMat(m));
        check("loadAck", {255'd0, bus.multFleg}, {255'd0, 1'b1});
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Requests a product and holds EN until the flag rises; leaves the block in DONE.
    task automatic runProduct();
        int edges;
        step(1'b1, 1'b1, 1'b0, '0);
        edges = 0;
        while (!bus.multFleg && edges < 40) begin
            step(1'b1, 1'b1, 1'b0, '0);
            edges++;
        end
        check("latency", 256'(edges), 256'(LAT));
    endtask

    function automatic logic [BUSW-1:0] randBus();
        logic [BUSW-1:0] v;
        for (int w = 0; w < BUSW/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    matT idM, seqM, twoM, threeM, ffM, hundM, tmpM;
    logic [BUSW-1:0] seqLit;

    initial begin
        bus.multEN = 1'b0; bus.multRW = 1'b0; bus.matDecide = 1'b0; bus.dataIn = '0;
        modelReset();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                idM[i][j]    = (i == j) ? 16'd1 : 16'd0;
                seqM[i][j]   = 16'(i*DIM + j + 1);
                twoM[i][j]   = 16'h0002;
                threeM[i][j] = 16'h0003;
                ffM[i][j]    = 16'h00FF;
                hundM[i][j]  = 16'h0100;
            end
        seqLit = 256'h0010000f000e000d000c000b000a00090008000700060005000400030002_0001;

        #1;
        check("reset dataOut", bus.dataOut, '0);
        check("reset multFleg", {255'd0, bus.multFleg}, '0);
        #1 RESET = 1'b0;
        checkEn = 1'b1;

        // Pin the model against hand-computed products.
        check("model identity", matMul(idM, seqM), seqLit);
        check("model 2x3", matMul(twoM, threeM), {16{16'h0018}});
        check("model ff wrap", matMul(ffM, ffM), {16{16'hF804}});

        // Identity times 1..16 returns B.
        loadMat(1'b0, idM);
        loadMat(1'b1, seqM);
        runProduct();
        check("identity result", bus.dataOut, seqLit);
        step(1'b0, 1'b0, 1'b0, '0);
        check("done exit flag", {255'd0, bus.multFleg}, '0);

        loadMat(1'b0, twoM);
        loadMat(1'b1, threeM);
        runProduct();
        check("2x3 result", bus.dataOut, {16{16'h0018}});
        step(1'b0, 1'b0, 1'b0, '0);

        loadMat(1'b0, ffM);
        loadMat(1'b1, ffM);
        runProduct();
        check("ff wrap result", bus.dataOut, {16{16'hF804}});
        step(1'b0, 1'b0, 1'b0, '0);

        loadMat(1'b0, hundM);
        loadMat(1'b1, hundM);
        runProduct();
        check("0x100 wrap result", bus.dataOut, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Loads while busy or done must not touch the operands.
        loadMat(1'b0, seqM);
        loadMat(1'b1, idM);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, randBus());
        step(1'b1, 1'b0, 1'b1, randBus());
        for (int n = 0; n < 40 && !bus.multFleg; n++) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, randBus());
        step(1'b0, 1'b0, 1'b0, '0);
        runProduct();
        check("operands kept", bus.dataOut, seqLit);
        step(1'b0, 1'b0, 1'b0, '0);

        // Abort at CALC cycle 5, then re-request.
        step(1'b1, 1'b1, 1'b0, '0);
        for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check("abort no flag", {255'd0, bus.multFleg}, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        runProduct();
        check("after abort", bus.dataOut, seqLit);
        step(1'b0, 1'b0, 1'b0, '0);

        // Randomized operands with occasional aborted requests.
        for (int t = 0; t < 12; t++) begin
            step(1'b1, 1'b0, 1'b0, randBus());
            step(1'b0, 1'b0, 1'b0, '0);
            step(1'b1, 1'b0, 1'b1, randBus());
            step(1'b0, 1'b0, 1'b0, '0);
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, 1'b1, 1'b0, '0);
                for (int n = 0; n < int'($urandom_range(0, 10)); n++) step(1'b1, 1'b1, 1'b0, '0);
                step(1'b0, 1'b0, 1'b0, '0);
            end
            runProduct();
            for (int n = 0; n < int'($urandom_range(0, 2)); n++) step(1'b1, 1'b1, 1'b0, '0);
            step(1'b0, 1'b0, 1'b0, '0);
        end

        // Asynchronous reset while DONE.
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) tmpM[i][j] = 16'(i + 2*j + 3);
        loadMat(1'b0, tmpM);
        loadMat(1'b1, tmpM);
        runProduct();
        #2 RESET = 1'b1;
        #1;
        check("async reset dataOut", bus.dataOut, '0);
        check("async reset multFleg", {255'd0, bus.multFleg}, '0);
        modelReset();
        RESET = 1'b0;
        runProduct();
        check("product after reset", bus.dataOut, '0);
        check("flag after reset", {255'd0, bus.multFleg}, {255'd0, 1'b1});
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
